// File: rtl/mcu_bus_pkg.sv
// mcu_bus_pkg: shared MCU register map (read-back and write-port addresses), read FSM states and screen defaults.
package mcu_bus_pkg;
  localparam int DEFAULT_SCREEN_WIDTH = 320;
  localparam int DEFAULT_SCREEN_HEIGHT = 240;
  localparam logic [2:0] REG_X_LOW = 3'd0;
  localparam logic [2:0] REG_X_HIGH = 3'd1;
  localparam logic [2:0] REG_Y = 3'd2;
  localparam logic [2:0] REG_DATA = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd5;
  // The write port shares the coordinate registers; its pixel register must stay clear of DATA/STATUS.
  localparam logic [2:0] WR_REG_X_LOW = 3'd0;
  localparam logic [2:0] WR_REG_X_HIGH = 3'd1;
  localparam logic [2:0] WR_REG_Y = 3'd2;
  localparam logic [2:0] WR_REG_PIXEL = 3'd4;
  typedef enum logic {StIdle, StWait} readStateT;
endpackage

// File: rtl/mcu_readback_interface_strobe_sync.sv
// strobe_sync: SYNC_STAGES-deep synchroniser for an MCU strobe with one-clock rise/fall pulses.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetN,
  input  logic strobe,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain;
  logic last;
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      chain <= '0;
      last <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], strobe};
      last <= chain[SYNC_STAGES-1];
    end
  end
  assign rise = chain[SYNC_STAGES-1] && !last;
  assign fall = !chain[SYNC_STAGES-1] && last;
endmodule

// File: rtl/mcu_readback_interface.sv
// mcu_readback_interface: MCU register-bus pixel read-back via the memory manager read port.
// Define MCU_READ_AUTOINC_EN to auto-advance X/Y and prefetch after each DATA read.
module mcu_readback_interface
  import mcu_bus_pkg::*;
#(
  parameter int SCREEN_WIDTH = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       resetN,
  output logic [8:0] memoryXCoord,
  output logic [7:0] memoryYCoord,
  output logic       memoryReadRequest,
  input  logic [7:0] memoryReadData,
  input  logic       memoryReadComplete,
  input  logic       mpuChipSelect,
  input  logic       mpuWriteEnable,
  input  logic [2:0] mpuRegisterSelect,
  inout  wire  [7:0] mpuDataBus
);
  logic [8:0] xReg;
  logic [7:0] yReg, dataReg, readValue;
  logic trigger, pending, busy, wRise, advance, xWrap, yWrap;
  readStateT state;
  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) writeSync (
    .clock(clock), .resetN(resetN), .strobe(mpuChipSelect && !mpuWriteEnable), .rise(wRise), .fall()
  );
  assign xWrap = xReg == 9'(SCREEN_WIDTH - 1);
  assign yWrap = yReg == 8'(SCREEN_HEIGHT - 1);
`ifdef MCU_READ_AUTOINC_EN
  logic rRise, rFall;
  logic [2:0] readSel;
  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) readSync (
    .clock(clock), .resetN(resetN), .strobe(mpuChipSelect && mpuWriteEnable), .rise(rRise), .fall(rFall)
  );
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) readSel <= '0;
    else if (rRise) readSel <= mpuRegisterSelect;
  end
  assign advance = rFall && readSel == REG_DATA;
`else
  assign advance = 1'b0;
`endif
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      xReg <= '0;
      yReg <= '0;
      trigger <= 1'b0;
    end else begin
      trigger <= 1'b0;
      if (advance) begin
        xReg <= xWrap ? '0 : xReg + 9'd1;
        yReg <= xWrap ? (yWrap ? '0 : yReg + 8'd1) : yReg;
        trigger <= 1'b1;
      end
      // Select and data are sampled once, on the first synchronised clock of the write strobe.
      if (wRise && mpuRegisterSelect == REG_X_LOW) begin
        xReg[7:0] <= mpuDataBus;
        trigger <= 1'b1;
      end
      if (wRise && mpuRegisterSelect == REG_X_HIGH) begin
        xReg[8] <= mpuDataBus[0];
        trigger <= 1'b1;
      end
      if (wRise && mpuRegisterSelect == REG_Y) begin
        yReg <= mpuDataBus;
        trigger <= 1'b1;
      end
    end
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= StIdle;
      memoryReadRequest <= 1'b0;
      memoryXCoord <= '0;
      memoryYCoord <= '0;
      dataReg <= '0;
      busy <= 1'b0;
      pending <= 1'b0;
    end else if (state == StIdle) begin
      if (trigger || pending) begin
        memoryXCoord <= xReg;
        memoryYCoord <= yReg;
        memoryReadRequest <= 1'b1;
        busy <= 1'b1;
        pending <= 1'b0;
        state <= StWait;
      end
    end else begin
      if (trigger) pending <= 1'b1;
      if (memoryReadComplete) begin
        dataReg <= memoryReadData;
        memoryReadRequest <= 1'b0;
        busy <= 1'b0;
        state <= StIdle;
      end
    end
  end
  always_comb begin
    readValue = mpuRegisterSelect == REG_X_LOW  ? xReg[7:0] :
                mpuRegisterSelect == REG_X_HIGH ? {7'b0, xReg[8]} :
                mpuRegisterSelect == REG_Y      ? yReg :
                mpuRegisterSelect == REG_DATA   ? dataReg :
                mpuRegisterSelect == REG_STATUS ? {6'b0, pending, busy} : 8'h00;
  end
  assign mpuDataBus = (mpuChipSelect && mpuWriteEnable) ? readValue : 8'hzz;
endmodule

// File: doc/mcu_readback_interface.md
# mcu_readback_interface

Read-back companion to the MCU pixel-write port. It lets the MCU fetch a framebuffer pixel over the same 8-bit register bus that the write port uses. The MCU loads X/Y coordinate registers; the block then issues a `memoryReadRequest`/`memoryReadComplete` handshake to the memory manager, latches the returned pixel and presents it in a DATA register, optionally auto-advancing the coordinate for streaming reads. It sits beside the write interface, on the memory manager's read port.

## Interface
- `SCREEN_WIDTH`, 320: pixels per line; X wraps to 0 at this value.
- `SCREEN_HEIGHT`, 240: lines; Y wraps to 0 at this value.
- `SYNC_STAGES`, 2: flip-flop depth of the MCU strobe synchroniser (≥2).
- `clock`  in  1: system clock; one clock domain; reset is asynchronous and active-low.
- `resetN`  in  1: asynchronous active-low reset.
- `memoryXCoord`  out  9: read X coordinate.
- `memoryYCoord`  out  8: read Y coordinate.
- `memoryReadRequest`  out  1: read request, held until complete.
- `memoryReadData`  in  8: pixel from the memory manager; valid while `memoryReadComplete` is high.
- `memoryReadComplete`  in  1: read done (pulse or level).
- `mpuChipSelect`  in  1: MCU chip select, active high.
- `mpuWriteEnable`  in  1: low = MCU write cycle, high = MCU read cycle (when selected).
- `mpuRegisterSelect`  in  3: register address.
- `mpuDataBus`  inout  8: MCU data bus. The block drives it only during a selected read cycle; otherwise it is Z.

## Operation
- Registers: 0 X_LOW (rw, X[7:0]); 1 X_HIGH (rw, bit0 = X[8]); 2 Y (rw); 3 DATA (ro, latched pixel); 5 STATUS (ro, {6'b0, pending, busy}). Other addresses read 0, and writes to them are ignored.
- Write strobe = CS && !WE; read strobe = CS && WE. Both strobes pass through the `SYNC_STAGES` synchroniser.
- Write capture: on the first clock the synchronised write strobe is seen high, the block samples `mpuRegisterSelect` and `mpuDataBus` once. The MCU holds them stable from strobe assertion for ≥ SYNC_STAGES+2 clocks.
- Any write to 0/1/2 sets `trigger`. The read FSM fires on the Y write only if Y is written last; the MCU writes X first, then Y.
- Read path: `mpuDataBus` is combinationally driven from the selected register whenever the raw read strobe is high.
- FSM states:
  - IDLE: on `trigger` or `pending`, copy the coordinates to `memoryXCoord`/`memoryYCoord`, assert `memoryReadRequest`, set busy, clear pending, go to WAIT.
  - WAIT: on `memoryReadComplete`=1, latch `memoryReadData` into DATA, deassert the request, clear busy, go to IDLE.
- Coordinate write while busy: the registers update, `pending` is set, and the in-flight read finishes unchanged. A new read starts the cycle after returning to IDLE.
- DATA read while busy returns the previous pixel; firmware polls STATUS.busy first.
- Arithmetic: X, Y unsigned. Written X ≥ SCREEN_WIDTH or Y ≥ SCREEN_HEIGHT are passed through unchanged, with no clamping.

## Timing
- Reset values: `memoryReadRequest` 0, `memoryXCoord` 0, `memoryYCoord` 0, DATA 0, STATUS 0, state IDLE, synchroniser 0, `mpuDataBus` Z.
- Write strobe to internal capture: SYNC_STAGES+1 clocks. Capture to `memoryReadRequest` high: 1 clock.
- Complete sampled high at edge N: DATA valid, request low and busy 0 after edge N. A complete seen in the same cycle as a request assertion is ignored.
- Minimum re-request gap: 1 IDLE cycle.
- Reset mid-operation: the request drops immediately (asynchronously), and pending/busy/DATA clear.

## Configuration
- `MCU_READ_AUTOINC_EN` defined:
  - The synchronised falling edge of a read strobe whose captured select was DATA advances X by 1.
  - At X = SCREEN_WIDTH-1, X goes to 0 and Y increments. At Y = SCREEN_HEIGHT-1, Y goes to 0.
  - The advance then triggers a new prefetch (or sets pending if busy).
- Undefined: DATA reads have no side effects; the coordinates change only on MCU writes.

## Structure
- Shared package `mcu_bus_pkg`: register address constants (including the write-port addresses, so map collisions are checked in one place), an FSM state enum, and the default screen dimensions.
- One sub-module, `strobe_sync`: a parameterised `SYNC_STAGES` synchroniser with rise/fall pulse outputs, used twice (read and write strobes).

## Test plan
- Write X_LOW=0x3F, X_HIGH=1, Y=5; memory completes 3 clocks after request with 0xA5 → `memoryXCoord`=319, `memoryYCoord`=5, request high for exactly 4 clocks, DATA read returns 0xA5, STATUS=0.
- With `MCU_READ_AUTOINC_EN`: after the previous DATA read → X=0, Y=6, new request issued. Repeat at X=319, Y=239 → X=0, Y=0.
- Write Y=7 while a read is in flight (busy) → STATUS=0x03 (pending+busy). The first read completes with the old coordinates; a second request with Y=7 starts 1 IDLE cycle later.
- Deassert `resetN` while the request is high → request low the same timestep, STATUS=0, DATA=0, bus Z; after release no request until the next coordinate write.
- Without the macro: two consecutive DATA reads → the coordinates are unchanged and no new request is issued.
- Bus direction: CS=0, or CS=1 with WE=0 → `mpuDataBus` Z from the block. CS=1, WE=1, select=2 → Y value driven.
